// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational ALU between two requesters.
//               It registers the winner's operands and returns result/zero
//               over a valid/ready response channel.
//               Build option ALU_ARB_FIXED_PRIO_EN selects fixed priority
//               (req0 wins ties); the default is round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int DW  = 16,
    parameter int OPW = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [DW-1:0]  req0_a,
    input  logic [DW-1:0]  req0_b,
    input  logic [OPW-1:0] req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [DW-1:0]  req1_a,
    input  logic [DW-1:0]  req1_b,
    input  logic [OPW-1:0] req1_op,
    output logic           resp0_valid,
    input  logic           resp0_ready,
    output logic           resp1_valid,
    input  logic           resp1_ready,
    output logic [DW-1:0]  resp_result,
    output logic           resp_zero,
    output logic [DW-1:0]  alu_data1,
    output logic [DW-1:0]  alu_data2,
    output logic [OPW-1:0] alu_op,
    input  logic [DW-1:0]  alu_result,
    input  logic           alu_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           grant_q, grant_d;
    logic [DW-1:0]  a_q, a_d;
    logic [DW-1:0]  b_q, b_d;
    logic [OPW-1:0] op_q, op_d;
    logic [DW-1:0]  result_q, result_d;
    logic           zero_q, zero_d;
    logic           winner;
    logic           accept;
    logic           resp_ready_sel;

`ifndef ALU_ARB_FIXED_PRIO_EN
    logic           last_grant_q, last_grant_d;
`endif

    // winner: 0 selects req0, 1 selects req1
    always_comb begin
        winner = ~req0_valid;
`ifndef ALU_ARB_FIXED_PRIO_EN
        if (req0_valid && req1_valid) begin
            winner = ~last_grant_q;
        end
`endif
    end

    assign req0_ready     = (state_q == S_IDLE) && req0_valid && !winner;
    assign req1_ready     = (state_q == S_IDLE) && req1_valid &&  winner;
    assign accept         = req0_ready || req1_ready;
    assign resp_ready_sel = grant_q ? resp1_ready : resp0_ready;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    grant_d = winner;
                    a_d     = winner ? req1_a  : req0_a;
                    b_d     = winner ? req1_b  : req0_b;
                    op_d    = winner ? req1_op : req0_op;
`ifndef ALU_ARB_FIXED_PRIO_EN
                    last_grant_d = winner;
`endif
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (resp_ready_sel) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            grant_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // ALU inputs come straight from the operand registers so they stay frozen until the next accept
    assign alu_data1   = a_q;
    assign alu_data2   = b_q;
    assign alu_op      = op_q;
    assign resp_result = result_q;
    assign resp_zero   = zero_q;
    assign resp0_valid = (state_q == S_RESP) && !grant_q;
    assign resp1_valid = (state_q == S_RESP) &&  grant_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter with an ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [1:0]  req0_op = '0, req1_op = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [15:0] resp_result;
    logic        resp_zero;
    logic [15:0] alu_data1, alu_data2, alu_result;
    logic [1:0]  alu_op;
    logic        alu_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.DW(16), .OPW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_result(resp_result), .resp_zero(resp_zero),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero)
    );

    // ALU model: ADD, SHIFT, ROTATE, SUB; b[0]=1 left, b[4:1]=amount
    logic [3:0] amt;
    always_comb begin
        amt        = alu_data2[4:1];
        alu_result = '0;
        case (alu_op)
            2'b00: alu_result = alu_data1 + alu_data2;
            2'b01: alu_result = alu_data2[0] ? (alu_data1 << amt) : (alu_data1 >> amt);
            2'b10: alu_result = alu_data2[0] ? ((alu_data1 << amt) | (alu_data1 >> (5'd16 - {1'b0, amt})))
                                             : ((alu_data1 >> amt) | (alu_data1 << (5'd16 - {1'b0, amt})));
            default: alu_result = alu_data1 - alu_data2;
        endcase
        alu_zero = (alu_result == 16'h0000);
    end

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_handshake: got %b expected 0000", {req0_ready, req1_ready, resp0_valid, resp1_valid});
        end
        checks++;
        if ({alu_data1, alu_data2, alu_op, resp_result, resp_zero} !== 51'd0) begin
            errors++;
            $display("FAIL reset_data: d1=%h d2=%h op=%b res=%h z=%b expected all 0",
                     alu_data1, alu_data2, alu_op, resp_result, resp_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0001; req0_op = 2'b00;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL add_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({req0_ready, resp0_valid, alu_data1, alu_data2, alu_op} !== {2'b00, 16'h1234, 16'h0001, 2'b00}) begin
            errors++;
            $display("FAIL add_exec: rdy=%b vld=%b d1=%h d2=%h op=%b expected 0 0 1234 0001 00",
                     req0_ready, resp0_valid, alu_data1, alu_data2, alu_op);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({resp0_valid, resp1_valid, resp_result, resp_zero} !== {2'b10, 16'h1235, 1'b0}) begin
            errors++;
            $display("FAIL add_resp: v0=%b v1=%b res=%h z=%b expected 1 0 1235 0",
                     resp0_valid, resp1_valid, resp_result, resp_zero);
        end
        resp0_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;
        #1;
        checks++;
        if (resp0_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_drop: resp0_valid=%b expected 0", resp0_valid);
        end
    endtask

    task automatic test_sub();
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 16'h00FF; req1_b = 16'h00FF; req1_op = 2'b11;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL sub_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if ({resp0_valid, resp1_valid, resp_result, resp_zero} !== {2'b01, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL sub_resp: v0=%b v1=%b res=%h z=%b expected 0 1 0000 1",
                     resp0_valid, resp1_valid, resp_result, resp_zero);
        end
        resp1_ready = 1'b1;
        @(negedge clk);
        resp1_ready = 1'b0;
    endtask

    task automatic test_alternate();
        logic exp;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_op = 2'b00;
        req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0002; req1_op = 2'b00;
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            exp = 1'b0;
`else
            exp = k[0];
`endif
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== {~exp, exp}) begin
                errors++;
                $display("FAIL alt_grant[%0d]: got %b expected %b", k, {req0_ready, req1_ready}, {~exp, exp});
            end
            @(negedge clk);
            @(negedge clk);
            #1;
            checks++;
            if ({resp0_valid, resp1_valid, resp_result} !== {~exp, exp, (exp ? 16'h0004 : 16'h0002)}) begin
                errors++;
                $display("FAIL alt_resp[%0d]: v0=%b v1=%b res=%h expected grant %0d", k,
                         resp0_valid, resp1_valid, resp_result, exp);
            end
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        resp0_ready = 1'b0; resp1_ready = 1'b0;
    endtask

    task automatic test_rotate_backpressure();
        req0_valid = 1'b1; req0_a = 16'h8001; req0_b = 16'h0003; req0_op = 2'b10;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL rot_ready: req0_ready=%b expected 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h0006; req1_op = 2'b00;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({resp0_valid, resp_result, resp_zero, req1_ready, alu_data1} !== {1'b1, 16'h0003, 1'b0, 1'b0, 16'h8001}) begin
                errors++;
                $display("FAIL rot_hold[%0d]: v0=%b res=%h z=%b r1=%b d1=%h expected 1 0003 0 0 8001",
                         i, resp0_valid, resp_result, resp_zero, req1_ready, alu_data1);
            end
            @(negedge clk);
        end
        resp0_ready = 1'b1;
        @(negedge clk);
        resp0_ready = 1'b0;
        #1;
        checks++;
        if ({resp0_valid, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL rot_release: v0=%b r1=%b expected 0 1", resp0_valid, req1_ready);
        end
        req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_exec();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 16'h00F0; req0_b = 16'h0008; req0_op = 2'b01;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstx_ready: req0_ready=%b expected 1", req0_ready);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({alu_data1, alu_data2, alu_op, resp_result, resp_zero, resp0_valid, resp1_valid, req0_ready, req1_ready} !== 55'd0) begin
            errors++;
            $display("FAIL rstx_clear: d1=%h d2=%h op=%b res=%h z=%b v=%b%b r=%b%b expected all 0",
                     alu_data1, alu_data2, alu_op, resp_result, resp_zero, resp0_valid, resp1_valid, req0_ready, req1_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({resp0_valid, resp1_valid} !== 2'b00) begin
                errors++;
                $display("FAIL rstx_noresp[%0d]: v=%b%b expected 00", i, resp0_valid, resp1_valid);
            end
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rstx_tie: got %b expected 10", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({req0_ready, req1_ready, resp0_valid, resp1_valid, alu_data1, alu_data2, alu_op} !== 38'd0) begin
                errors++;
                $display("FAIL idle[%0d]: r=%b%b v=%b%b d1=%h d2=%h op=%b expected all 0",
                         i, req0_ready, req1_ready, resp0_valid, resp1_valid, alu_data1, alu_data2, alu_op);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_alternate();
        test_rotate_backpressure();
        test_reset_exec();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
